// File: rtl/e1_frame_align.sv
// G.704 E1 basic frame aligner: finds FAS in TS0, confirms via NFAS and a second FAS,
// then tags each delayed bit with timeslot/bit/frame parity and tracks loss of frame.
module e1_frame_align #(
  parameter logic [6:0]  FASPAT = 7'b0011011,
  parameter int unsigned LOFN   = 3
) (
  input  logic       clk2,
  input  logic       rst,
  input  logic       serin,
  output logic       serout,
  output logic [4:0] tsnum,
  output logic [2:0] bitnum,
  output logic       frmodd,
  output logic       lof,
  output logic       fasok,
  output logic       faserr
);

  typedef enum logic [1:0] {SEARCH, CHK_NFAS, CHK_FAS2, SYNC} state_t;

  localparam logic [1:0] LOFN_C = 2'(LOFN);

  state_t     state, state_nx;
  logic [6:0] hist, hist_nx;
  logic [7:0] pos, pos_nx;
  logic       odd, odd_nx;
  logic [1:0] errcnt, errcnt_nx, errcnt_inc;
  logic       match, fas_pt, nfas_pt;
  logic       fasok_nx, faserr_nx, reseed;

  // hist_nx is the 7-bit window ending with the bit arriving this cycle.
  assign hist_nx    = {hist[5:0], serin};
  assign match      = (hist_nx == FASPAT);
  assign fas_pt     = (pos == 8'd7) && !odd;
  assign nfas_pt    = (pos == 8'd1) && odd;
  assign errcnt_inc = errcnt + 2'd1;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_nx  = state;
    errcnt_nx = errcnt;
    fasok_nx  = 1'b0;
    faserr_nx = 1'b0;
    unique case (state)
      SEARCH: begin
        if (match) state_nx = CHK_NFAS;
      end
      CHK_NFAS: begin
        if (nfas_pt) state_nx = serin ? CHK_FAS2 : SEARCH;
      end
      CHK_FAS2: begin
        if (fas_pt) begin
          if (match) begin
            state_nx  = SYNC;
            errcnt_nx = 2'd0;
            fasok_nx  = 1'b1;
          end else begin
            state_nx = SEARCH;
          end
        end
      end
      SYNC: begin
        if (fas_pt) begin
          if (match) begin
            errcnt_nx = 2'd0;
            fasok_nx  = 1'b1;
          end else begin
            faserr_nx = 1'b1;
            errcnt_nx = errcnt_inc;
            if (errcnt_inc == LOFN_C) begin
              state_nx  = SEARCH;
              errcnt_nx = 2'd0;
            end
          end
        end
      end
    endcase
    // A match re-seeds the counters while searching, and also on the cycle a check fails.
    reseed = match && ((state == SEARCH) || (state_nx == SEARCH));
    pos_nx = reseed ? 8'd8 : pos + 8'd1;
    odd_nx = reseed ? 1'b0 : (odd ^ (pos == 8'hff));
  end

  always_ff @(posedge clk2) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst) begin
      state  <= SEARCH;
      hist   <= '0;
      pos    <= '0;
      odd    <= 1'b0;
      errcnt <= '0;
      serout <= 1'b0;
      tsnum  <= '0;
      bitnum <= '0;
      frmodd <= 1'b0;
      lof    <= 1'b1;
      fasok  <= 1'b0;
      faserr <= 1'b0;
    end else begin
      state  <= state_nx;
      hist   <= hist_nx;
      pos    <= pos_nx;
      odd    <= odd_nx;
      errcnt <= errcnt_nx;
      serout <= serin;
      tsnum  <= pos[7:3];
      bitnum <= pos[2:0];
      frmodd <= odd;
      lof    <= (state_nx != SYNC);
      fasok  <= fasok_nx;
      faserr <= faserr_nx;
    end
  end

endmodule

// File: tb/tb_e1_frame_align.sv
// Self-checking bench for e1_frame_align: framed E1 stream generator, a position-based
// reference model (bit offset within the 512-bit double frame) and lock-timing milestones.
module tb_e1_frame_align;

  localparam logic [6:0] FAS  = 7'b0011011;
  localparam int         LOFN = 3;

  logic       clk2 = 1'b0;
  logic       rst;
  logic       serin;
  logic       serout;
  logic [4:0] tsnum;
  logic [2:0] bitnum;
  logic       frmodd, lof, fasok, faserr;

  e1_frame_align #(.FASPAT(FAS), .LOFN(LOFN)) dut (
    .clk2   (clk2),
    .rst    (rst),
    .serin  (serin),
    .serout (serout),
    .tsnum  (tsnum),
    .bitnum (bitnum),
    .frmodd (frmodd),
    .lof    (lof),
    .fasok  (fasok),
    .faserr (faserr)
  );

  always #5 clk2 = ~clk2;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Stream generator: g is the phase of the next bit within an even+odd frame pair.
  int g = 0;
  bit rand_pl = 1'b0;
  bit ts5 = 1'b0;
  int fas_bad_left = 0;
  int nfas_bad_left = 0;

  task automatic gen(output logic b);
    int gg;
    bit od;
    gg = g % 256;
    od = (g >= 256);
    b = rand_pl ? 1'($urandom_range(0, 1)) : 1'b1;
    if (gg < 8) begin
      if (gg == 0) begin
        // Si bit: payload value
      end else if (!od) begin
        b = FAS[7-gg];
        if (fas_bad_left > 0 && gg == 4) b = ~b;
      end else if (gg == 1) begin
        b = (nfas_bad_left > 0) ? 1'b0 : 1'b1;
      end
    end else if (ts5 && gg >= 40 && gg <= 46) begin
      b = FAS[46-gg];
    end
    if (g == 7 && fas_bad_left > 0) fas_bad_left--;
    if (g == 257 && nfas_bad_left > 0) nfas_bad_left--;
    g = (g + 1) % 512;
  endtask

  // Reference model: the position of a bit is its offset from the last alignment base.
  int         mc = 0;
  int         base = 0;
  int         mode = 0;  // 0 searching, 1 awaiting NFAS, 2 awaiting second FAS, 3 in frame
  int         errs = 0;
  logic [6:0] win = '0;

  // Milestone tracking (n = input cycle index since reset release).
  int n = 0;
  int last_fall, last_rise, rises, fasok_seen, faserr_seen;
  logic prev_lof = 1'b1;

  task automatic clear_marks();
    last_fall = -1;
    last_rise = -1;
    rises = 0;
    fasok_seen = 0;
    faserr_seen = 0;
  endtask

  task automatic cycle(input logic rv);
    logic b, m;
    int p;
    logic e_ser, e_fr, e_lof, e_ok, e_err;
    int e_ts, e_bit;
    gen(b);
    @(negedge clk2);
    rst = rv;
    serin = b;
    e_ser = 1'b0; e_ts = 0; e_bit = 0; e_fr = 1'b0;
    e_lof = 1'b1; e_ok = 1'b0; e_err = 1'b0;
    if (!rv) begin
      win = '0; mode = 0; errs = 0; base = mc + 1;
    end else begin
      win = {win[5:0], b};
      m = (win == FAS);
      p = ((mc - base) % 512 + 512) % 512;
      e_ser = b;
      e_ts  = (p % 256) / 8;
      e_bit = p % 8;
      e_fr  = (p >= 256);
      case (mode)
        0: if (m) begin base = mc - 7; mode = 1; end
        1: if (p == 257) begin
             if (b) mode = 2;
             else begin mode = 0; if (m) base = mc - 7; end
           end
        2: if (p == 7) begin
             if (m) begin mode = 3; errs = 0; e_ok = 1'b1; end
             else mode = 0;
           end
        default: if (p == 7) begin
             if (m) begin errs = 0; e_ok = 1'b1; end
             else begin
               e_err = 1'b1;
               errs++;
               if (errs == LOFN) begin mode = 0; errs = 0; end
             end
           end
      endcase
      e_lof = (mode != 3);
    end
    mc++;
    @(posedge clk2);
    #1;
    check("serout", serout, e_ser);
    check("tsnum", tsnum, e_ts);
    check("bitnum", bitnum, e_bit);
    check("frmodd", frmodd, e_fr);
    check("lof", lof, e_lof);
    check("fasok", fasok, e_ok);
    check("faserr", faserr, e_err);
    if (rv) begin
      if (fasok === 1'b1) fasok_seen++;
      if (faserr === 1'b1) faserr_seen++;
      if (prev_lof === 1'b1 && lof === 1'b0) last_fall = n + 1;
      if (prev_lof === 1'b0 && lof === 1'b1) begin last_rise = n + 1; rises++; end
      n++;
    end else begin
      n = 0;
    end
    prev_lof = lof;
  endtask

  task automatic do_reset(input int len, input int g_after);
    for (int i = 0; i < len; i++) cycle(1'b0);
    if (g_after >= 0) g = g_after;
    clear_marks();
  endtask

  task automatic run_until(input int target);
    while (n < target) cycle(1'b1);
  endtask

  task automatic run_to_phase(input int ph);
    for (int i = 0; i < 512 && g != ph; i++) cycle(1'b1);
  endtask

  int n1, k;

  initial begin
    rst = 1'b0;
    serin = 1'b0;
    clear_marks();

    // Clean all-ones framed stream, FAS ending at input cycle 100.
    do_reset(3, 419);
    check("reset_lof", lof, 1);
    check("reset_tsnum", tsnum, 0);
    rand_pl = 1'b0;
    run_until(3001);
    check("clean_lock_cycle", last_fall, 613);
    check("clean_fasok_count", fasok_seen, 5);
    check("clean_no_loss", rises, 0);

    // Random payload while in frame.
    clear_marks();
    rand_pl = 1'b1;
    repeat (2048) cycle(1'b1);
    check("rand_fasok_count", fasok_seen, 4);
    check("rand_no_faserr", faserr_seen, 0);
    check("rand_no_loss", rises, 0);

    // Two bad FAS, a good one, two bad again: error count must clear in between.
    clear_marks();
    run_to_phase(300);
    fas_bad_left = 2;
    repeat (1100) cycle(1'b1);
    run_to_phase(300);
    fas_bad_left = 2;
    repeat (1700) cycle(1'b1);
    check("two_err_faserr_count", faserr_seen, 4);
    check("two_err_no_loss", rises, 0);
    check("two_err_lof", lof, 0);

    // Three consecutive bad FAS: loss of frame, then relock on the next good FAS.
    rand_pl = 1'b0;
    run_to_phase(300);
    clear_marks();
    n1 = n + 219;
    fas_bad_left = 3;
    run_until(n1 + 2100);
    check("lof_faserr_count", faserr_seen, 3);
    check("lof_rise_cycle", last_rise, n1 + 1025);
    check("lof_relock_cycle", last_fall, n1 + 2049);

    // Bad NFAS in the first odd frame: restart search, lock on the following sequence.
    do_reset(2, 419);
    nfas_bad_left = 1;
    run_until(1400);
    check("nfas_lock_cycle", last_fall, 1125);
    check("nfas_fasok_count", fasok_seen, 1);

    // FAS-like pattern in TS5 of every frame; true FAS arrives first.
    do_reset(2, 500);
    ts5 = 1'b1;
    run_until(3000);
    check("ts5_lock_cycle", last_fall, 532);
    check("ts5_no_loss", rises, 0);
    check("ts5_fasok_count", fasok_seen, 5);
    check("ts5_no_faserr", faserr_seen, 0);

    // One-cycle reset while in frame, then relock.
    ts5 = 1'b0;
    run_to_phase(100);
    do_reset(1, -1);
    check("midrst_lof", lof, 1);
    check("midrst_fasok", fasok, 0);
    check("midrst_bitnum", bitnum, 0);
    k = (7 - g + 512) % 512;
    run_until(k + 600);
    check("midrst_relock_cycle", last_fall, k + 513);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
